// File: rtl/fetch_exc_stage.sv
// Fetch-stage exception unit and F/D pipeline register: range/alignment check on
// the fetched PC, wrong-path squash after ERET, and fetch blanking after a fault.
module fetch_exc_stage #(
  parameter int unsigned             ADDR_W     = 32,
  parameter int unsigned             NREG       = 1,
  parameter logic [NREG*ADDR_W-1:0]  REG_BASE   = 32'h0000_3000,
  parameter logic [NREG*ADDR_W-1:0]  REG_LIMIT  = 32'h0000_4fff,
  parameter int unsigned             ALIGN_BITS = 2,
  parameter int unsigned             CODE_W     = 5,
  parameter logic [CODE_W-1:0]       EXC_ADEL   = CODE_W'(4),
  parameter logic [CODE_W-1:0]       EXC_NULL   = CODE_W'(0),
  parameter int unsigned             CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic              f_valid,
  input  logic              eret_d,
  input  logic              stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] d_pc,
  output logic              d_valid,
  output logic [CODE_W-1:0] d_exc_code,
  output logic [CNT_W-1:0]  exc_count,
  output logic              hold_state
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t state, state_nx;

  logic              in_region;
  logic              misaligned;
  logic              bad_pc;
  logic              load;
  logic              cnt_inc;
  logic              d_valid_nx;
  logic [CODE_W-1:0] d_code_nx;

  always_comb begin
    in_region = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (f_pc >= REG_BASE[i*ADDR_W +: ADDR_W] && f_pc <= REG_LIMIT[i*ADDR_W +: ADDR_W])
        in_region = 1'b1;
    end
  end

  assign misaligned = |f_pc[ALIGN_BITS-1:0];
  assign bad_pc     = f_valid && (misaligned || !in_region);

  // flush overrides stall, so the D register loads on either condition
  assign load = flush || !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush)
      state_nx = RUN;
    else if (!stall && state == RUN && !eret_d && bad_pc)
      state_nx = HOLD;
  end

  always_comb begin
    d_valid_nx = 1'b0;
    d_code_nx  = EXC_NULL;
    cnt_inc    = 1'b0;
    if (!flush && !stall && state == RUN && !eret_d) begin
      if (bad_pc) begin
        d_valid_nx = 1'b1;
        d_code_nx  = EXC_ADEL;
        cnt_inc    = 1'b1;
      end else begin
        d_valid_nx = f_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_pc       <= '0;
      d_valid    <= 1'b0;
      d_exc_code <= EXC_NULL;
    end else if (load) begin
      d_pc       <= f_pc;
      d_valid    <= d_valid_nx;
      d_exc_code <= d_code_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      exc_count <= '0;
    else if (cnt_inc && exc_count != '1)
      exc_count <= exc_count + 1'b1;
  end

  assign hold_state = (state == HOLD);

endmodule

// File: tb/tb_fetch_exc_stage.sv
// Directed bench for fetch_exc_stage: a default instance and a two-region instance
// with a narrow counter, both checked every cycle against a behavioural model.
module tb_fetch_exc_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f_pc;
  logic        f_valid, eret_d, stall, flush;

  logic [31:0] d_pc0, d_pc1;
  logic        d_valid0, d_valid1;
  logic [4:0]  code0, code1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;
  logic        hold0, hold1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_exc_stage dut0 (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_valid(f_valid), .eret_d(eret_d),
    .stall(stall), .flush(flush), .d_pc(d_pc0), .d_valid(d_valid0),
    .d_exc_code(code0), .exc_count(cnt0), .hold_state(hold0)
  );

  fetch_exc_stage #(
    .NREG(2),
    .REG_BASE({32'h0000_4180, 32'h0000_3000}),
    .REG_LIMIT({32'h0000_4ffc, 32'h0000_3fff}),
    .CNT_W(3)
  ) dut1 (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_valid(f_valid), .eret_d(eret_d),
    .stall(stall), .flush(flush), .d_pc(d_pc1), .d_valid(d_valid1),
    .d_exc_code(code1), .exc_count(cnt1), .hold_state(hold1)
  );

  // Behavioural model: per-instance region tables and saturation limits
  int unsigned lo  [2][2] = '{'{32'h3000, 32'h3000}, '{32'h3000, 32'h4180}};
  int unsigned hi  [2][2] = '{'{32'h4fff, 32'h4fff}, '{32'h3fff, 32'h4ffc}};
  int          nreg[2]    = '{1, 2};
  int unsigned cmax[2]    = '{65535, 7};

  int unsigned m_pc   [2];
  bit          m_valid[2];
  int unsigned m_code [2];
  int unsigned m_cnt  [2];
  bit          m_hold [2];

  function automatic bit legal(int k, int unsigned pc);
    if (pc % 4 != 0) return 1'b0;
    for (int r = 0; r < nreg[k]; r++)
      if (pc >= lo[k][r] && pc <= hi[k][r]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_pc[k] = 0; m_valid[k] = 0; m_code[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
      end else if (flush) begin
        m_pc[k] = f_pc; m_valid[k] = 0; m_code[k] = 0; m_hold[k] = 0;
      end else if (!stall) begin
        m_pc[k] = f_pc; m_valid[k] = 0; m_code[k] = 0;
        if (!m_hold[k] && !eret_d) begin
          if (f_valid && !legal(k, f_pc)) begin
            m_valid[k] = 1; m_code[k] = 4; m_hold[k] = 1;
            if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
          end else begin
            m_valid[k] = f_valid;
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m0.d_pc",  d_pc0,           m_pc[0]);
    chk("m0.valid", {31'd0, d_valid0}, {31'd0, m_valid[0]});
    chk("m0.code",  {27'd0, code0},  m_code[0]);
    chk("m0.cnt",   {16'd0, cnt0},   m_cnt[0]);
    chk("m0.hold",  {31'd0, hold0},  {31'd0, m_hold[0]});
    chk("m1.d_pc",  d_pc1,           m_pc[1]);
    chk("m1.valid", {31'd0, d_valid1}, {31'd0, m_valid[1]});
    chk("m1.code",  {27'd0, code1},  m_code[1]);
    chk("m1.cnt",   {29'd0, cnt1},   m_cnt[1]);
    chk("m1.hold",  {31'd0, hold1},  {31'd0, m_hold[1]});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit0(string tag, int unsigned pc, bit v, int unsigned c, int unsigned n, bit h);
    chk({tag, ".d_pc"},  d_pc0, pc);
    chk({tag, ".valid"}, {31'd0, d_valid0}, {31'd0, v});
    chk({tag, ".code"},  {27'd0, code0}, c);
    chk({tag, ".cnt"},   {16'd0, cnt0}, n);
    chk({tag, ".hold"},  {31'd0, hold0}, {31'd0, h});
  endtask

  initial begin
    reset = 1'b0; f_pc = '0; f_valid = 1'b0; eret_d = 1'b0; stall = 1'b0; flush = 1'b0;
    step(); step();
    lit0("reset", 0, 0, 0, 0, 0);

    reset = 1'b1; f_pc = 32'h3000; f_valid = 1'b1;
    step();
    lit0("first", 32'h3000, 1, 0, 0, 0);

    f_pc = 32'h3002; step();
    lit0("misalign", 32'h3002, 1, 4, 1, 1);
    f_pc = 32'h5000; step();
    lit0("in_hold", 32'h5000, 0, 0, 1, 1);
    flush = 1'b1; step();
    lit0("flush", 32'h5000, 0, 0, 1, 0);
    flush = 1'b0;

    eret_d = 1'b1; f_pc = 32'h5000; step();
    lit0("eret_bad", 32'h5000, 0, 0, 1, 0);
    eret_d = 1'b0;

    f_pc = 32'h3000; step();
    stall = 1'b1; f_pc = 32'h2ffc;
    repeat (3) step();
    lit0("stalled", 32'h3000, 1, 0, 1, 0);
    stall = 1'b0; step();
    lit0("unstall", 32'h2ffc, 1, 4, 2, 1);

    flush = 1'b1; stall = 1'b1; f_pc = 32'h3001; step();
    lit0("flush_stall", 32'h3001, 0, 0, 2, 0);
    flush = 1'b0; stall = 1'b0; f_pc = 32'h5000; step();
    lit0("hold_again", 32'h5000, 1, 4, 3, 1);
    #2 reset = 1'b0;
    #1 lit0("async_rst", 0, 0, 0, 0, 0);
    step();
    reset = 1'b1;

    stall = 1'b1; eret_d = 1'b1; f_pc = 32'h5000;
    repeat (2) step();
    lit0("eret_stall", 0, 0, 0, 0, 0);
    stall = 1'b0; step();
    lit0("eret_release", 32'h5000, 0, 0, 0, 0);
    eret_d = 1'b0;

    f_pc = 32'h4180; step();
    chk("r2.4180.code", {27'd0, code1}, 0);
    chk("r2.4180.valid", {31'd0, d_valid1}, 1);
    f_pc = 32'h4000; step();
    chk("r2.4000.code", {27'd0, code1}, 4);
    chk("r1.4000.code", {27'd0, code0}, 0);
    flush = 1'b1; step(); flush = 1'b0;
    f_pc = 32'h4ffc; step();
    chk("r2.4ffc.code", {27'd0, code1}, 0);
    chk("r2.4ffc.valid", {31'd0, d_valid1}, 1);
    lit0("legal_4ffc", 32'h4ffc, 1, 0, 0, 0);
    f_pc = 32'h4ffe; step();
    lit0("misalign_4ffe", 32'h4ffe, 1, 4, 1, 1);
    flush = 1'b1; step(); flush = 1'b0;

    f_valid = 1'b0; f_pc = 32'h5000; step();
    lit0("invalid_bad", 32'h5000, 0, 0, 1, 0);
    f_valid = 1'b1;

    for (int i = 0; i < 10; i++) begin
      f_pc = 32'h2ffc; step();
      chk("sat.code", {27'd0, code1}, 4);
      chk("sat.hold", {31'd0, hold1}, 1);
      flush = 1'b1; step(); flush = 1'b0;
    end
    chk("sat.cnt1", {29'd0, cnt1}, 7);
    chk("sat.cnt0", {16'd0, cnt0}, 11);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
